// File: rtl/tape_arbiter_if.sv
// Bus bundle between tape_arbiter, its two requesters (core, host) and the single-port tape RAM.
interface tape_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              init_done;

    // Arbiter side.
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output core_gnt, core_rvalid, core_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_we, mem_addr, mem_wdata,
        output init_done
    );

    // Requesters plus RAM side.
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  core_gnt, core_rvalid, core_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  init_done
    );
endinterface

// File: rtl/tape_arbiter.sv
// Tape RAM arbiter: zero-fills the tape after reset, then grants one core/host access per cycle.
// Define TAPE_ARB_ROUND_ROBIN_EN for round-robin on contention; default is fixed host > core.
module tape_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned CLEAR_DEPTH = 65536
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    tape_arbiter_if.slave  bus_io
);
    typedef enum logic [0:0] {StClear, StIdle} state_e;

    localparam state_e      StReset    = (CLEAR_DEPTH == 0) ? StIdle : StClear;
    localparam int unsigned ClearLastI = (CLEAR_DEPTH == 0) ? 0 : CLEAR_DEPTH - 1;
    localparam logic [ADDR_W:0] ClearLast = ClearLastI[ADDR_W:0];

    state_e            state_q, state_d;
    logic [ADDR_W:0]   clear_cnt_q, clear_cnt_d;
    logic              init_done_q, init_done_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [ADDR_W-1:0] mem_addr_q;

    logic              core_gnt, host_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef TAPE_ARB_ROUND_ROBIN_EN
    logic rr_last_host_q, rr_last_host_d;
`endif

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        core_gnt    = 1'b0;
        host_gnt    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = mem_addr_q;
        mem_wdata   = '0;
        unique case (state_q)
            StClear: begin
                mem_we      = 1'b1;
                mem_addr    = clear_cnt_q[ADDR_W-1:0];
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == ClearLast) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // init_done_q also keeps grants off while reset is held with CLEAR_DEPTH == 0.
                if (init_done_q) begin
`ifdef TAPE_ARB_ROUND_ROBIN_EN
                    if (bus_io.host_req && bus_io.core_req) begin
                        host_gnt = ~rr_last_host_q;
                        core_gnt = rr_last_host_q;
                    end else begin
                        host_gnt = bus_io.host_req;
                        core_gnt = bus_io.core_req;
                    end
`else
                    host_gnt = bus_io.host_req;
                    core_gnt = bus_io.core_req & ~bus_io.host_req;
`endif
                end
                if (host_gnt) begin
                    mem_we    = bus_io.host_we;
                    mem_addr  = bus_io.host_addr;
                    mem_wdata = bus_io.host_wdata;
                end else if (core_gnt) begin
                    mem_we    = bus_io.core_we;
                    mem_addr  = bus_io.core_addr;
                    mem_wdata = bus_io.core_wdata;
                end
            end
            default: state_d = StReset;
        endcase
        init_done_d   = (state_d == StIdle);
        core_rvalid_d = core_gnt & ~bus_io.core_we;
        host_rvalid_d = host_gnt & ~bus_io.host_we;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StReset;
            clear_cnt_q   <= '0;
            init_done_q   <= 1'b0;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            clear_cnt_q   <= clear_cnt_d;
            init_done_q   <= init_done_d;
            core_rvalid_q <= core_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            mem_addr_q    <= mem_addr;
        end
    end

`ifdef TAPE_ARB_ROUND_ROBIN_EN
    always_comb begin
        rr_last_host_d = rr_last_host_q;
        if (host_gnt) begin
            rr_last_host_d = 1'b1;
        end else if (core_gnt) begin
            rr_last_host_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_last_host_q <= 1'b0;
        end else begin
            rr_last_host_q <= rr_last_host_d;
        end
    end
`endif

    // The clear sweep state resets into StClear, so the write strobe must be masked during reset.
    assign bus_io.mem_we      = mem_we & rst_ni;
    assign bus_io.mem_addr    = mem_addr;
    assign bus_io.mem_wdata   = mem_wdata;
    assign bus_io.core_gnt    = core_gnt;
    assign bus_io.host_gnt    = host_gnt;
    assign bus_io.core_rvalid = core_rvalid_q;
    assign bus_io.host_rvalid = host_rvalid_q;
    assign bus_io.core_rdata  = bus_io.mem_rdata;
    assign bus_io.host_rdata  = bus_io.mem_rdata;
    assign bus_io.init_done   = init_done_q;
endmodule
